fpu_add_issue: RTL and testbench

FPU_ADD_ISSUE -- requirements
Module: fpu_add_issue

---
 rtl/fpu_add_issue.sv | 159 +++++++++++++++
 tb/tb_fpu_add_issue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_issue.sv
// Issue/return wrapper around a fixed-latency external fadd: credit-limited issue, tag pipeline, in-order result FIFO.
// Optional subtract support is enabled with macro FPU_ADD_SUB_EN.
`timescale 1ns/1ps
module fpu_add_issue #(
  parameter int LAT   = 2,
  parameter int TAGW  = 6,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic [TAGW-1:0] req_tag,
`ifdef FPU_ADD_SUB_EN
  input  logic            req_sub,
`endif
  output logic [31:0]     fa_x1,
  output logic [31:0]     fa_x2,
  input  logic [31:0]     fa_y,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_y,
  output logic [TAGW-1:0] res_tag,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = 32 + TAGW;

  logic [CW-1:0]   credit_reg;
  logic            accept;
  logic            pop;
  logic            push;
  logic [DW-1:0]   push_data;

  logic [LAT-1:0]  vld_sr_reg;
  logic [TAGW-1:0] tag_sr_reg [LAT];

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   head_reg;
  logic [DW-1:0]   head_next;
  logic            fifo_full;
  logic            fifo_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fa_x1 = req_x1;
`ifdef FPU_ADD_SUB_EN
  assign fa_x2 = req_sub ? {~req_x2[31], req_x2[30:0]} : req_x2;
`else
  assign fa_x2 = req_x2;
`endif

  assign req_ready = (credit_reg < CW'(DEPTH));
  assign busy      = (credit_reg != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = res_valid && res_ready;

  // Credits cover both in-flight ops and FIFO entries, so the FIFO cannot overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_reg <= '0;
    end else if (accept && !pop) begin
      credit_reg <= credit_reg + CW'(1);
    end else if (pop && !accept) begin
      credit_reg <= credit_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr_reg[0] <= 1'b0;
      tag_sr_reg[0] <= '0;
    end else begin
      vld_sr_reg[0] <= accept;
      tag_sr_reg[0] <= req_tag;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_sr_reg[gi] <= 1'b0;
          tag_sr_reg[gi] <= '0;
        end else begin
          vld_sr_reg[gi] <= vld_sr_reg[gi-1];
          tag_sr_reg[gi] <= tag_sr_reg[gi-1];
        end
      end
    end
  endgenerate

  assign push       = vld_sr_reg[LAT-1];
  assign push_data  = {fa_y, tag_sr_reg[LAT-1]};
  assign fifo_full  = (cnt_reg == CW'(DEPTH));
  assign fifo_empty = (cnt_reg == '0);
  assign res_valid  = !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // The head register always holds the oldest entry; a push into an empty
  // (or emptying) FIFO bypasses the array so there is no bubble.
  always_comb begin
    head_next = head_reg;
    if (pop) begin
      if (cnt_reg == CW'(1)) begin
        if (push) begin
          head_next = push_data;
        end
      end else begin
        head_next = mem[ptr_inc(rd_ptr_reg)];
      end
    end else if (fifo_empty && push) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      head_reg   <= '0;
    end else begin
      head_reg <= head_next;
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        cnt_reg <= cnt_reg + CW'(1);
      end else if (pop && !push) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  assign res_y   = head_reg[DW-1:TAGW];
  assign res_tag = head_reg[TAGW-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full));

endmodule

// File: tb/tb_fpu_add_issue.sv
// Directed-vector bench for fpu_add_issue: a fixed-latency fadd model, a scoreboard queue
// filled on accept and a negedge monitor comparing every popped result.
`timescale 1ns/1ps
module tb_fpu_add_issue;
  localparam int LAT   = 2;
  localparam int TAGW  = 6;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_x1;
  logic [31:0]     req_x2;
  logic [TAGW-1:0] req_tag;
`ifdef FPU_ADD_SUB_EN
  logic            req_sub;
`endif
  logic [31:0]     fa_x1;
  logic [31:0]     fa_x2;
  logic [31:0]     fa_y;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_y;
  logic [TAGW-1:0] res_tag;
  logic            busy;

  int total = 0;
  int bad   = 0;
  logic [TAGW+31:0] sb_q [$];
  logic [TAGW+31:0] sb_e;
  logic [31:0]      exp_y;
  logic [31:0]      fpipe [LAT];

  logic [31:0] s_x1  [5] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000};
  logic [31:0] s_x2  [5] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000};
  logic [31:0] s_sum [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40800000, 32'h40A00000};

  always #5 clk = ~clk;

  fpu_add_issue #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
`ifdef FPU_ADD_SUB_EN
    .req_sub(req_sub),
`endif
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_tag(res_tag), .busy(busy)
  );

  // Stand-in fadd: small table of exact small-integer sums, NaN otherwise.
  function automatic logic [31:0] fadd_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_3F800000: return 32'h40000000;
      64'h3F800000_40000000: return 32'h40400000;
      64'h40000000_40000000: return 32'h40800000;
      64'h40400000_3F800000: return 32'h40800000;
      64'h40400000_40000000: return 32'h40A00000;
      64'h40400000_BF800000: return 32'h40000000;
      default:               return 32'h7FC00000;
    endcase
  endfunction

  always @(posedge clk) begin
    fpipe[0] <= fadd_fn(fa_x1, fa_x2);
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fa_y = fpipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (req_valid && req_ready) sb_q.push_back({exp_y, req_tag});
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result actual=y %h tag %0d required=no result", res_y, res_tag);
        end else begin
          sb_e = sb_q.pop_front();
          $display("result y=%h tag=%0d", res_y, res_tag);
          chk("res_y", 64'(res_y), 64'(sb_e[TAGW+31:TAGW]));
          chk("res_tag", 64'(res_tag), 64'(sb_e[TAGW-1:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] x1, input logic [31:0] x2, input int tag, input logic [31:0] ey);
    req_valid = 1'b1;
    req_x1    = x1;
    req_x2    = x2;
    req_tag   = TAGW'(tag);
    exp_y     = ey;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_x1 = '0; req_x2 = '0; req_tag = '0;
    res_ready = 1'b1; exp_y = '0;
`ifdef FPU_ADD_SUB_EN
    req_sub = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_res_y", 64'(res_y), 0);
    chk("rst_res_tag", 64'(res_tag), 0);
    rstn = 1'b1;
    tick();

    // Single op: latency of exactly 3 edges including the accept edge.
    drive(32'h3F800000, 32'h40000000, 5, 32'h40400000);
    chk("pass_fa_x1", 64'(fa_x1), 64'h3F800000);
    chk("pass_fa_x2", 64'(fa_x2), 64'h40000000);
    tick();
    req_valid = 1'b0;
    chk("lat_edge1", 64'(res_valid), 0);
    chk("lat_busy", 64'(busy), 1);
    tick();
    chk("lat_edge2", 64'(res_valid), 0);
    tick();
    chk("lat_edge3", 64'(res_valid), 1);
    repeat (3) tick();
    chk("s1_drained", 64'(sb_q.size()), 0);
    chk("s1_idle", 64'(busy), 0);

    // Four back-to-back requests with res_ready high.
    for (int k = 0; k < 4; k++) begin
      drive(s_x1[k], s_x2[k], k + 1, s_sum[k]);
      chk("b2b_req_ready", 64'(req_ready), 1);
      tick();
    end
    req_valid = 1'b0;
    chk("b2b_valid_c1", 64'(res_valid), 1);
    tick();
    chk("b2b_valid_c2", 64'(res_valid), 1);
    tick();
    chk("b2b_valid_c3", 64'(res_valid), 1);
    tick();
    chk("b2b_valid_end", 64'(res_valid), 0);
    repeat (2) tick();
    chk("s2_drained", 64'(sb_q.size()), 0);

    // Credit limit with res_ready low.
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(s_x1[k], s_x2[k], k + 10, s_sum[k]);
      chk("credit_ready", 64'(req_ready), 1);
      tick();
    end
    drive(s_x1[4], s_x2[4], 14, s_sum[4]);
    repeat (4) tick();
    chk("full_req_ready", 64'(req_ready), 0);
    chk("full_busy", 64'(busy), 1);
    chk("full_res_valid", 64'(res_valid), 1);
    chk("full_pending", 64'(sb_q.size()), 4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("after_pop_ready", 64'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    chk("fifth_accepted_ready", 64'(req_ready), 0);
    chk("fifth_pending", 64'(sb_q.size()), 4);
    res_ready = 1'b1;
    repeat (10) tick();
    chk("s3_drained", 64'(sb_q.size()), 0);
    chk("s3_idle", 64'(busy), 0);

`ifdef FPU_ADD_SUB_EN
    drive(32'h40400000, 32'h3F800000, 9, 32'h40000000);
    req_sub = 1'b1;
    chk("sub_fa_x2", 64'(fa_x2), 64'hBF800000);
    tick();
    req_valid = 1'b0;
    req_sub = 1'b0;
    repeat (5) tick();
    chk("sub_drained", 64'(sb_q.size()), 0);
`else
    req_x2 = 32'hBF800000;
    chk("nosub_fa_x2", 64'(fa_x2), 64'hBF800000);
`endif

    // Reset with operations in flight.
    drive(s_x1[0], s_x2[0], 20, s_sum[0]);
    tick();
    drive(s_x1[1], s_x2[1], 21, s_sum[1]);
    tick();
    req_valid = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    chk("arst_res_valid", 64'(res_valid), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_req_ready", 64'(req_ready), 1);
    chk("arst_res_y", 64'(res_y), 0);
    sb_q.delete();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("no_stale", 64'(res_valid), 0);
    end
    drive(32'h40000000, 32'h40000000, 7, 32'h40800000);
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("post_rst_drained", 64'(sb_q.size()), 0);
    chk("post_rst_idle", 64'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
